// File: rtl/lsq_mc.sv
// In-order load/store queue: holds memory ops in program order, wakes operands from CDB broadcasts,
// issues one request at a time to memctrl and returns load results / store completions.
module lsq_mc #(
    parameter int DEPTH = 16,
    parameter int ROB_W = 4,
    parameter int NCDB  = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    enq_valid,
    input  logic [5:0]              enq_op,
    input  logic [31:0]             enq_vj,
    input  logic [31:0]             enq_vk,
    input  logic [ROB_W-1:0]        enq_qj,
    input  logic [ROB_W-1:0]        enq_qk,
    input  logic                    enq_j,
    input  logic                    enq_k,
    input  logic [31:0]             enq_imm,
    input  logic [ROB_W-1:0]        enq_rob_id,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  free_cnt,
    input  logic [NCDB-1:0]         cdb_valid,
    input  logic [NCDB*ROB_W-1:0]   cdb_id,
    input  logic [NCDB*32-1:0]      cdb_val,
    input  logic [ROB_W-1:0]        rob_head,
    input  logic                    flush,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [2:0]              mem_width,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ack,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic                    ld_valid,
    output logic [ROB_W-1:0]        ld_rob_id,
    output logic [31:0]             ld_value,
    output logic                    st_done,
    output logic [ROB_W-1:0]        st_rob_id
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = NCDB + 1;

    localparam logic [5:0] OP_LB  = 6'd10, OP_LH  = 6'd11, OP_LW = 6'd12, OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14, OP_SB  = 6'd15, OP_SH = 6'd16;

    typedef struct packed {
        logic             valid;
        logic [5:0]       op;
        logic             j;
        logic             k;
        logic [ROB_W-1:0] qj;
        logic [ROB_W-1:0] qk;
        logic [ROB_W-1:0] rob_id;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      imm;
    } ent_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    function automatic logic [2:0] op_width(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_width = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_width = 3'd2;
            default:              op_width = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] ld_ext(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_LB:   ld_ext = {{24{d[7]}}, d[7:0]};
            OP_LH:   ld_ext = {{16{d[15]}}, d[15:0]};
            OP_LBU:  ld_ext = {24'b0, d[7:0]};
            OP_LHU:  ld_ext = {16'b0, d[15:0]};
            OP_LW:   ld_ext = d;
            default: ld_ext = d;
        endcase
    endfunction

    ent_t             q [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [AW:0]      count;
    state_t           state, state_nx;
    logic [5:0]       cur_op;
    logic [ROB_W-1:0] cur_rob;

    logic                      enq_ok, issue, pop, ld_pulse, st_pulse, head_rdy;
    ent_t                      head_e;
    logic [NW-1:0]             wk_v;
    logic [NW-1:0][ROB_W-1:0]  wk_id;
    logic [NW-1:0][31:0]       wk_val;
    logic [DEPTH-1:0]          hit_j, hit_k;
    logic [DEPTH-1:0][31:0]    val_j, val_k;
    logic                      byp_j, byp_k;
    logic [31:0]               byp_vj, byp_vk;

    assign full     = count == (AW+1)'(DEPTH);
    assign free_cnt = (AW+1)'(DEPTH) - count;
    assign enq_ok   = enq_valid && !full;
    assign head_e   = q[head];
    assign head_rdy = head_e.valid && head_e.j && head_e.k &&
                      (head_e.op < OP_SB || rob_head == head_e.rob_id);

    // The queue's own load result is treated as one extra broadcast channel.
    always_comb begin
        for (int c = 0; c < NCDB; c++) begin
            wk_v[c]   = cdb_valid[c];
            wk_id[c]  = cdb_id[c*ROB_W +: ROB_W];
            wk_val[c] = cdb_val[c*32 +: 32];
        end
        wk_v[NCDB]   = ld_valid;
        wk_id[NCDB]  = ld_rob_id;
        wk_val[NCDB] = ld_value;
    end

    // Scan channels high to low so the lowest matching channel is the one that sticks.
    always_comb begin
        hit_j  = '0;
        hit_k  = '0;
        val_j  = '0;
        val_k  = '0;
        byp_j  = 1'b0;
        byp_k  = 1'b0;
        byp_vj = enq_vj;
        byp_vk = enq_vk;
        for (int c = NW-1; c >= 0; c--) begin
            if (wk_v[c]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (wk_id[c] == q[e].qj) begin hit_j[e] = 1'b1; val_j[e] = wk_val[c]; end
                    if (wk_id[c] == q[e].qk) begin hit_k[e] = 1'b1; val_k[e] = wk_val[c]; end
                end
                if (wk_id[c] == enq_qj) begin byp_j = 1'b1; byp_vj = wk_val[c]; end
                if (wk_id[c] == enq_qk) begin byp_k = 1'b1; byp_vk = wk_val[c]; end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     state <= S_IDLE;
        else if (rdy_in) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        pop      = 1'b0;
        ld_pulse = 1'b0;
        st_pulse = 1'b0;
        case (state)
            S_IDLE: if (!flush && head_rdy) begin
                issue    = 1'b1;
                state_nx = S_REQ;
            end
            S_REQ: begin
                if (mem_ack) begin
                    pop = 1'b1;
                    if (mem_we) begin
                        st_pulse = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = flush ? S_DRAIN : S_WAIT;
                    end
                end else if (flush) begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    ld_pulse = !flush;
                    state_nx = S_IDLE;
                end else if (flush) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: if (mem_rvalid) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int e = 0; e < DEPTH; e++) q[e] <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_width <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cur_op    <= '0;
            cur_rob   <= '0;
            ld_valid  <= 1'b0;
            ld_rob_id <= '0;
            ld_value  <= '0;
            st_done   <= 1'b0;
            st_rob_id <= '0;
        end else if (rdy_in) begin
            ld_valid <= ld_pulse;
            st_done  <= st_pulse;
            if (st_pulse) st_rob_id <= cur_rob;
            if (ld_pulse) begin
                ld_rob_id <= cur_rob;
                ld_value  <= ld_ext(cur_op, mem_rdata);
            end

            if (issue) begin
                mem_req   <= 1'b1;
                mem_we    <= head_e.op >= OP_SB;
                mem_width <= op_width(head_e.op);
                mem_addr  <= head_e.vj + head_e.imm;
                case (op_width(head_e.op))
                    3'd1:    mem_wdata <= {24'b0, head_e.vk[7:0]};
                    3'd2:    mem_wdata <= {16'b0, head_e.vk[15:0]};
                    default: mem_wdata <= head_e.vk;
                endcase
                cur_op  <= head_e.op;
                cur_rob <= head_e.rob_id;
            end else if (state == S_REQ && state_nx != S_REQ) begin
                mem_req <= 1'b0;
            end

            if (flush) begin
                for (int e = 0; e < DEPTH; e++) q[e].valid <= 1'b0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (q[e].valid && !q[e].j && hit_j[e]) begin q[e].vj <= val_j[e]; q[e].j <= 1'b1; end
                    if (q[e].valid && !q[e].k && hit_k[e]) begin q[e].vk <= val_k[e]; q[e].k <= 1'b1; end
                end
                if (pop) begin
                    q[head].valid <= 1'b0;
                    head          <= head + 1'b1;
                end
                if (enq_ok) begin
                    q[tail] <= '{valid: 1'b1, op: enq_op,
                                 j: enq_j || byp_j, k: enq_k || byp_k,
                                 qj: enq_qj, qk: enq_qk, rob_id: enq_rob_id,
                                 vj: enq_j ? enq_vj : byp_vj,
                                 vk: enq_k ? enq_vk : byp_vk,
                                 imm: enq_imm};
                    tail <= tail + 1'b1;
                end
                count <= count + (AW+1)'(enq_ok) - (AW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_lsq_mc.sv
// Directed + randomized bench for lsq_mc; acts as memctrl and checks every request/result
// against expected values derived from the op semantics.
module tb_lsq_mc;
    localparam int DEPTH = 16;
    localparam int ROB_W = 4;
    localparam int NCDB  = 2;

    logic                   clk_in, rst_in, rdy_in;
    logic                   enq_valid, enq_j, enq_k;
    logic [5:0]             enq_op;
    logic [31:0]            enq_vj, enq_vk, enq_imm;
    logic [ROB_W-1:0]       enq_qj, enq_qk, enq_rob_id;
    logic                   full;
    logic [4:0]             free_cnt;
    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*ROB_W-1:0]  cdb_id;
    logic [NCDB*32-1:0]     cdb_val;
    logic [ROB_W-1:0]       rob_head;
    logic                   flush;
    logic                   mem_req, mem_we, mem_ack, mem_rvalid;
    logic [2:0]             mem_width;
    logic [31:0]            mem_addr, mem_wdata, mem_rdata;
    logic                   ld_valid, st_done;
    logic [ROB_W-1:0]       ld_rob_id, st_rob_id;
    logic [31:0]            ld_value;

    lsq_mc #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NCDB(NCDB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .enq_valid(enq_valid), .enq_op(enq_op), .enq_vj(enq_vj), .enq_vk(enq_vk),
        .enq_qj(enq_qj), .enq_qk(enq_qk), .enq_j(enq_j), .enq_k(enq_k),
        .enq_imm(enq_imm), .enq_rob_id(enq_rob_id), .full(full), .free_cnt(free_cnt),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .rob_head(rob_head),
        .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ld_valid(ld_valid),
        .ld_rob_id(ld_rob_id), .ld_value(ld_value), .st_done(st_done), .st_rob_id(st_rob_id)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rob;
    } exp_t;
    exp_t mq[$];

    function automatic logic [2:0] exp_width(input logic [5:0] op);
        if (op == 6'd10 || op == 6'd13 || op == 6'd15) return 3'd1;
        if (op == 6'd11 || op == 6'd14 || op == 6'd16) return 3'd2;
        return 3'd4;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] vk);
        longint m = longint'(1) << (8 * int'(exp_width(op)));
        longint v = longint'(vk) % m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] d);
        longint v = longint'(d);
        case (op)
            6'd10: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            6'd11: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            6'd13: v = v % 256;
            6'd14: v = v % 65536;
            default: ;
        endcase
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_enq(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [3:0] qj, input logic j, input logic [31:0] imm,
                           input logic [3:0] rob);
        enq_valid = 1'b1; enq_op = op; enq_vj = vj; enq_vk = vk; enq_qj = qj; enq_j = j;
        enq_qk = 4'd0; enq_k = 1'b1; enq_imm = imm; enq_rob_id = rob;
    endtask

    task automatic enq(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] qj, input logic j, input logic [31:0] imm,
                       input logic [3:0] rob);
        set_enq(op, vj, vk, qj, j, imm, rob);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 40) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'b0, mem_req}, 32'd1);
    endtask

    // Plays memctrl for the op at the queue head; data is store value or raw load data.
    task automatic serve(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] rob);
        logic st = op >= 6'd15;
        rob_head = rob;
        wait_req();
        if (!mem_req) return;
        chk("addr", mem_addr, addr);
        chk("width", {29'b0, mem_width}, {29'b0, exp_width(op)});
        chk("we", {31'b0, mem_we}, {31'b0, st});
        if (st) chk("wdata", mem_wdata, exp_wdata(op, data));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("req_drop", {31'b0, mem_req}, 32'd0);
        if (st) begin
            chk("st_done", {31'b0, st_done}, 32'd1);
            chk("st_rob", {28'b0, st_rob_id}, {28'b0, rob});
            tick();
            chk("st_done_end", {31'b0, st_done}, 32'd0);
        end else begin
            mem_rdata  = data;
            mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0;
            chk("ld_valid", {31'b0, ld_valid}, 32'd1);
            chk("ld_rob", {28'b0, ld_rob_id}, {28'b0, rob});
            chk("ld_value", ld_value, exp_load(op, data));
            tick();
            chk("ld_valid_end", {31'b0, ld_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] base, imm, vk, d;
        logic [5:0]  op;
        exp_t        e;

        rst_in = 1'b0; rdy_in = 1'b1; enq_valid = 1'b0; enq_op = '0; enq_vj = '0; enq_vk = '0;
        enq_qj = '0; enq_qk = '0; enq_j = 1'b0; enq_k = 1'b0; enq_imm = '0; enq_rob_id = '0;
        cdb_valid = '0; cdb_id = '0; cdb_val = '0; rob_head = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // reset state
        #12;
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_free", {27'b0, free_cnt}, 32'd16);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_ld", {31'b0, ld_valid}, 32'd0);
        chk("rst_st", {31'b0, st_done}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        @(posedge clk_in); #1 rst_in = 1'b1;
        tick();

        // reset asserted while a request is outstanding
        enq(6'd12, 32'h40, 32'h0, 4'd0, 1'b1, 32'h0, 4'd1);
        tick();
        chk("t1_req", {31'b0, mem_req}, 32'd1);
        #2 rst_in = 1'b0;
        #1 chk("t1_async_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk_in); #1 rst_in = 1'b1;
        tick();
        chk("t1_free", {27'b0, free_cnt}, 32'd16);

        // load address/latency and extension
        enq(6'd12, 32'h1000, 32'h0, 4'd0, 1'b1, 32'h4, 4'd1);
        tick();
        chk("t2_latency", {31'b0, mem_req}, 32'd1);
        serve(6'd12, 32'h1004, 32'hFFFFFF80, 4'd1);
        chk("t2_lw", ld_value, 32'hFFFFFF80);
        enq(6'd10, 32'h1000, 32'h0, 4'd0, 1'b1, 32'h4, 4'd2);
        serve(6'd10, 32'h1004, 32'hFFFFFF80, 4'd2);
        chk("t2_lb", ld_value, 32'hFFFFFF80);
        enq(6'd13, 32'h1000, 32'h0, 4'd0, 1'b1, 32'h4, 4'd3);
        serve(6'd13, 32'h1004, 32'hFFFFFF80, 4'd3);
        chk("t2_lbu", ld_value, 32'h00000080);

        // store waits for ROB head; pulse holds while not ready
        rob_head = 4'd3;
        enq(6'd15, 32'h2000, 32'h12345678, 4'd0, 1'b1, 32'h0, 4'd5);
        repeat (4) tick();
        chk("t3_hold", {31'b0, mem_req}, 32'd0);
        rob_head = 4'd5;
        wait_req();
        chk("t3_wdata", mem_wdata, 32'h78);
        chk("t3_we", {31'b0, mem_we}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t3_st_done", {31'b0, st_done}, 32'd1);
        chk("t3_st_rob", {28'b0, st_rob_id}, 32'd5);
        rdy_in = 1'b0;
        tick();
        chk("t3_rdy_hold", {31'b0, st_done}, 32'd1);
        rdy_in = 1'b1;
        tick();
        chk("t3_pulse_end", {31'b0, st_done}, 32'd0);

        // fill to full with random ops waiting on tag 9, wake them, drain in order (wraps)
        for (int r = 0; r < 2; r++) begin
            base = $urandom;
            for (int i = 0; i < DEPTH; i++) begin
                op  = 6'(10 + $urandom_range(0, 7));
                imm = $urandom;
                vk  = $urandom;
                d   = (op >= 6'd15) ? vk : $urandom;
                enq(op, 32'hDEADBEEF, vk, 4'd9, 1'b0, imm, 4'(i));
                e.op = op; e.addr = base + imm; e.data = d; e.rob = 4'(i);
                mq.push_back(e);
            end
            chk("t4_full", {31'b0, full}, 32'd1);
            chk("t4_free0", {27'b0, free_cnt}, 32'd0);
            enq(6'd12, 32'h0, 32'h0, 4'd0, 1'b1, 32'hDEAD0000, 4'd15);
            chk("t4_refused", {27'b0, free_cnt}, 32'd0);
            cdb_id = {4'd10, 4'd9}; cdb_val = {32'h11110000, base}; cdb_valid = 2'b11;
            tick();
            cdb_valid = 2'b00;
            while (mq.size() > 0) begin
                e = mq.pop_front();
                serve(e.op, e.addr, e.data, e.rob);
            end
            repeat (5) tick();
            chk("t4_no_extra", {31'b0, mem_req}, 32'd0);
            chk("t4_free", {27'b0, free_cnt}, 32'd16);
        end

        // wakeup via channel 1
        enq(6'd12, 32'h0, 32'h0, 4'd7, 1'b0, 32'h30, 4'd4);
        repeat (3) tick();
        chk("t5_wait", {31'b0, mem_req}, 32'd0);
        cdb_id = {4'd7, 4'd3}; cdb_val = {32'h200, 32'h999}; cdb_valid = 2'b11;
        tick();
        cdb_valid = 2'b00;
        serve(6'd12, 32'h230, $urandom, 4'd4);
        // wakeup from own load result
        enq(6'd12, 32'h100, 32'h0, 4'd0, 1'b1, 32'h0, 4'd2);
        enq(6'd11, 32'h0, 32'h0, 4'd2, 1'b0, 32'h8, 4'd3);
        serve(6'd12, 32'h100, 32'h3000, 4'd2);
        serve(6'd11, 32'h3008, $urandom, 4'd3);
        // enqueue coincident with broadcast
        cdb_id = {4'd0, 4'd12}; cdb_val = {32'h0, 32'h500}; cdb_valid = 2'b01;
        enq(6'd12, 32'h0, 32'h0, 4'd12, 1'b0, 32'h20, 4'd6);
        cdb_valid = 2'b00;
        serve(6'd12, 32'h520, $urandom, 4'd6);

        // flush while requesting
        enq(6'd12, 32'h40, 32'h0, 4'd0, 1'b1, 32'h0, 4'd1);
        wait_req();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_req_flush", {31'b0, mem_req}, 32'd0);
        chk("t6_req_free", {27'b0, free_cnt}, 32'd16);
        // flush while waiting for load data, with a same-cycle enqueue
        enq(6'd12, 32'h80, 32'h0, 4'd0, 1'b1, 32'h0, 4'd2);
        wait_req();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        flush = 1'b1;
        set_enq(6'd12, 32'h700, 32'h0, 4'd0, 1'b1, 32'h0, 4'd7);
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        chk("t6_flush_free", {27'b0, free_cnt}, 32'd16);
        enq(6'd12, 32'h900, 32'h0, 4'd0, 1'b1, 32'h0, 4'd3);
        repeat (3) tick();
        chk("t6_drain_hold", {31'b0, mem_req}, 32'd0);
        mem_rdata = 32'h55; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("t6_swallow", {31'b0, ld_valid}, 32'd0);
        serve(6'd12, 32'h900, 32'h1234ABCD, 4'd3);
        repeat (3) tick();
        chk("t6_empty", {27'b0, free_cnt}, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
